// File: rtl/vga_plot_arbiter_if.sv
// Drawer-side and VGA-side signal bundle for vga_plot_arbiter.
// master: drawers/adapter view; slave: the arbiter itself.
interface vga_plot_arbiter_if #(
  parameter int unsigned N_REQ = 8
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   pix_valid;
  logic [N_REQ-1:0]   pix_last;
  logic [8*N_REQ-1:0] pix_x;
  logic [7*N_REQ-1:0] pix_y;
  logic [3*N_REQ-1:0] pix_colour;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [2:0]         vga_colour;
  logic               vga_plot;
  logic               busy;
  logic               timeout_err;
  logic [14:0]        burst_count;

  modport master (
    output req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
    input  gnt, done, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err, burst_count
  );

  modport slave (
    input  req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
    output gnt, done, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err, burst_count
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing the vga_adapter pixel port among N_REQ drawers.
// Optional PLOT_ARB_CLIP_EN: accepted off-screen pixels are counted but not plotted.
module vga_plot_arbiter #(
  parameter int unsigned N_REQ       = 8,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               resetn,
  vga_plot_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;
  localparam logic [14:0]     CntMax  = 15'h7fff;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REQ - 1);
`ifdef PLOT_ARB_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [IdxW-1:0]  w_q, w_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             terr_q, terr_d;
  logic [14:0]      cnt_q, cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       c_q, c_d;
  logic             plot_q, plot_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] scan_idx;
  logic [IdxW-1:0] rr_after;
  logic            cur_req, cur_valid, cur_last, accept, fwd;
  logic [7:0]      cur_x;
  logic [6:0]      cur_y;
  logic [2:0]      cur_c;

  // First requester at or after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    scan_idx  = rr_q;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IdxLast) ? '0 : scan_idx + 1'b1;
    end
  end

  assign cur_req   = bus.req[w_q];
  assign cur_valid = bus.pix_valid[w_q];
  assign cur_last  = bus.pix_last[w_q];
  assign cur_x     = bus.pix_x[int'(w_q) * 8 +: 8];
  assign cur_y     = bus.pix_y[int'(w_q) * 7 +: 7];
  assign cur_c     = bus.pix_colour[int'(w_q) * 3 +: 3];
  assign rr_after  = (w_q == IdxLast) ? '0 : w_q + 1'b1;
  assign fwd       = !ClipEn || ((32'(cur_x) < SCREEN_W) && (32'(cur_y) < SCREEN_H));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    w_d     = w_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          w_d     = win_idx;
          gnt_d   = '0;
          gnt_d[win_idx] = 1'b1;
          cnt_d   = '0;
          tmr_d   = '0;
        end
      end
      StGrant: begin
        // A pixel offered in the same cycle the request drops is discarded.
        accept = cur_valid && cur_req;
        if (accept) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 15'd1;
          tmr_d = '0;
          if (fwd) begin
            plot_d = 1'b1;
            x_d    = cur_x;
            y_d    = cur_y;
            c_d    = cur_c;
          end
          if (cur_last) begin
            state_d     = StIdle;
            gnt_d       = '0;
            rr_d        = rr_after;
            done_d[w_q] = 1'b1;
          end
        end else if (!cur_req) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = rr_after;
        end else if (tmr_q == TmrLast) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = rr_after;
          terr_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      rr_q    <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      w_q     <= w_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.vga_x       = x_q;
  assign bus.vga_y       = y_q;
  assign bus.vga_colour  = c_q;
  assign bus.vga_plot    = plot_q;
  assign bus.busy        = (state_q == StGrant);
  assign bus.timeout_err = terr_q;
  assign bus.burst_count = cnt_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: vector table, directed corner sequences and random traffic
// checked every cycle against a behavioural model of the arbitration rules.
module tb_vga_plot_arbiter;
  localparam int N  = 8;
  localparam int TO = 16;
`ifdef PLOT_ARB_CLIP_EN
  localparam bit ClipOn = 1'b1;
`else
  localparam bit ClipOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.N_REQ(N)) bus ();

  vga_plot_arbiter #(
    .N_REQ(N), .SCREEN_W(160), .SCREEN_H(120), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  string tag = "init";

  // Model state: owner < 0 means nobody holds the port.
  int         m_owner, m_rr, m_cnt, m_tmr;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  logic       m_plot, m_terr;
  logic [N-1:0] m_done;

  typedef struct {
    logic [7:0] req, valid, last;
    int         lane;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [7:0] e_gnt, e_done;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    int         e_cnt;
  } vec_t;
  vec_t t2 [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_cnt = 0; m_tmr = 0;
    m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_terr = 1'b0; m_done = '0;
  endtask

  task automatic model_step();
    int w;
    bit found;
    logic [7:0] px;
    logic [6:0] py;
    m_done = '0; m_terr = 1'b0; m_plot = 1'b0; found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        w = (m_rr + k) % N;
        if (!found && bus.req[w]) begin
          found = 1; m_owner = w; m_cnt = 0; m_tmr = 0;
        end
      end
    end else begin
      w = m_owner;
      if (bus.pix_valid[w] && bus.req[w]) begin
        px = bus.pix_x[8*w +: 8];
        py = bus.pix_y[7*w +: 7];
        if (!ClipOn || (px < 160 && py < 120)) begin
          m_plot = 1'b1; m_x = px; m_y = py; m_c = bus.pix_colour[3*w +: 3];
        end
        if (m_cnt < 32767) m_cnt++;
        m_tmr = 0;
        if (bus.pix_last[w]) begin
          m_done[w] = 1'b1; m_rr = (w + 1) % N; m_owner = -1;
        end
      end else if (!bus.req[w]) begin
        m_rr = (w + 1) % N; m_owner = -1;
      end else if (m_tmr == TO - 1) begin
        m_terr = 1'b1; m_rr = (w + 1) % N; m_owner = -1;
      end else begin
        m_tmr++;
      end
    end
  endtask

  task automatic check_model();
    check("gnt", bus.gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("done", bus.done, m_done);
    check("busy", bus.busy, m_owner >= 0);
    check("terr", bus.timeout_err, m_terr);
    check("plot", bus.vga_plot, m_plot);
    check("x", bus.vga_x, m_x);
    check("y", bus.vga_y, m_y);
    check("colour", bus.vga_colour, m_c);
    check("count", bus.burst_count, m_cnt);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_pix(input int d, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c);
    bus.pix_x[8*d +: 8]      = x;
    bus.pix_y[7*d +: 7]      = y;
    bus.pix_colour[3*d +: 3] = c;
  endtask

  task automatic junk_lanes();
    for (int d = 0; d < N; d++) set_pix(d, 8'($urandom), 7'($urandom), 3'($urandom));
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int d = 0; d < N; d++) if (v[d]) r = d;
    return r;
  endfunction

  int order[$];
  int sent, g, dens;

  initial begin
    t2[0] = '{8'h04, 8'h00, 8'h00, 2, 8'd0,  7'd0, 3'd0, 8'h04, 8'h00, 1'b0, 8'd0,  7'd0, 3'd0, 0};
    t2[1] = '{8'h04, 8'h04, 8'h00, 2, 8'd10, 7'd5, 3'd4, 8'h04, 8'h00, 1'b1, 8'd10, 7'd5, 3'd4, 1};
    t2[2] = '{8'h04, 8'h04, 8'h00, 2, 8'd11, 7'd5, 3'd4, 8'h04, 8'h00, 1'b1, 8'd11, 7'd5, 3'd4, 2};
    t2[3] = '{8'h04, 8'h04, 8'h04, 2, 8'd12, 7'd5, 3'd4, 8'h00, 8'h04, 1'b1, 8'd12, 7'd5, 3'd4, 3};
    t2[4] = '{8'h00, 8'h00, 8'h00, 2, 8'd0,  7'd0, 3'd0, 8'h00, 8'h00, 1'b0, 8'd12, 7'd5, 3'd4, 3};

    resetn = 1'b0;
    bus.req = '0; bus.pix_valid = '0; bus.pix_last = '0;
    junk_lanes();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tag = "reset";
    check_model();
    #2 resetn = 1'b1;

    // Single burst from the vector table
    tag = "t2";
    for (int i = 0; i < 5; i++) begin
      bus.req = t2[i].req; bus.pix_valid = t2[i].valid; bus.pix_last = t2[i].last;
      set_pix(t2[i].lane, t2[i].x, t2[i].y, t2[i].c);
      step();
      check("vec.gnt", bus.gnt, t2[i].e_gnt);
      check("vec.done", bus.done, t2[i].e_done);
      check("vec.plot", bus.vga_plot, t2[i].e_plot);
      check("vec.x", bus.vga_x, t2[i].e_x);
      check("vec.y", bus.vga_y, t2[i].e_y);
      check("vec.colour", bus.vga_colour, t2[i].e_c);
      check("vec.count", bus.burst_count, t2[i].e_cnt);
    end

    // Reset in the middle of a burst
    tag = "t1";
    bus.req = 8'h04; step();
    bus.pix_valid = 8'h04; set_pix(2, 8'd20, 7'd7, 3'd1); step();
    bus.pix_valid = 8'h04; set_pix(2, 8'd21, 7'd7, 3'd1);
    resetn = 1'b0;
    #1;
    model_reset();
    check_model();
    #1 resetn = 1'b1;
    #1 check("gnt_after_release", bus.gnt, 32'd0);
    bus.req = '0; bus.pix_valid = '0; step();

    // Move rr_ptr to 2 via a grant to drawer 1 that is aborted at once
    tag = "t3";
    bus.req = 8'h02; step();
    bus.req = 8'h00; step();
    for (int d = 0; d < N; d++) set_pix(d, 8'(40 + d), 7'(10 + d), 3'(d));
    bus.req = 8'h0b; sent = 0; order.delete();
    for (int cyc = 0; cyc < 30 && order.size() < 3; cyc++) begin
      g = onehot_idx(bus.gnt);
      bus.pix_valid = bus.gnt | 8'h01;
      bus.pix_last  = (sent == 1) ? bus.gnt : 8'h00;
      step();
      if (g >= 0) begin
        sent++;
        if (sent == 2) begin
          bus.req[g] = 1'b0; sent = 0;
        end
      end
      if (bus.gnt != 0 && g < 0) order.push_back(onehot_idx(bus.gnt));
    end
    check("order_n", order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < order.size()) check("order", order[i], (i == 0) ? 3 : i - 1);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      g = onehot_idx(bus.gnt);
      bus.pix_valid = bus.gnt;
      bus.pix_last  = (sent == 1) ? bus.gnt : 8'h00;
      step();
      if (g >= 0) begin
        sent++;
        if (sent == 2) begin
          bus.req[g] = 1'b0; sent = 0;
        end
      end
    end
    bus.req = '0; bus.pix_valid = '0; bus.pix_last = '0; step();

    // Timeout on drawer 5, drawer 6 waiting
    tag = "t4";
    bus.req = 8'h60; step();
    check("grant5", bus.gnt, 32'h20);
    repeat (TO - 1) step();
    check("still5", bus.gnt, 32'h20);
    step();
    check("revoked", bus.gnt, 32'h00);
    check("terr_pulse", bus.timeout_err, 32'd1);
    check("no_done", bus.done, 32'h00);
    step();
    check("grant6", bus.gnt, 32'h40);
    check("terr_clear", bus.timeout_err, 32'd0);
    bus.req = '0; step();

    // Clipping
    tag = "t5";
    bus.req = 8'h10; step();
    bus.pix_valid = 8'h10; set_pix(4, 8'd160, 7'd10, 3'd5); step();
    check("plot_off", bus.vga_plot, ClipOn ? 32'd0 : 32'd1);
    bus.pix_last = 8'h10; set_pix(4, 8'd159, 7'd119, 3'd6); step();
    check("plot_on", bus.vga_plot, 32'd1);
    check("x_on", bus.vga_x, 32'd159);
    check("count2", bus.burst_count, 32'd2);
    bus.req = '0; bus.pix_valid = '0; bus.pix_last = '0; step();

    // Abort after 4 pixels
    tag = "t6";
    bus.req = 8'h02; step();
    for (int i = 0; i < 4; i++) begin
      bus.pix_valid = 8'h02; set_pix(1, 8'(50 + i), 7'd3, 3'd2); step();
    end
    bus.req = 8'h00; set_pix(1, 8'd99, 7'd3, 3'd2); step();
    check("abort_gnt", bus.gnt, 32'h00);
    check("abort_done", bus.done, 32'h00);
    check("abort_count", bus.burst_count, 32'd4);
    check("abort_plot", bus.vga_plot, 32'd0);
    bus.pix_valid = '0; step();

    // Random traffic
    tag = "rand";
    dens = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 5;
          2: dens = 50;
          default: dens = 90;
        endcase
      end
      for (int d = 0; d < N; d++) begin
        if (!bus.req[d] && $urandom_range(0, 7) == 0) bus.req[d] = 1'b1;
        else if (bus.req[d] && $urandom_range(0, 63) == 0) bus.req[d] = 1'b0;
        bus.pix_valid[d] = ($urandom_range(0, 99) < dens);
        bus.pix_last[d]  = ($urandom_range(0, 5) == 0);
      end
      junk_lanes();
      step();
      bus.req = bus.req & ~bus.done;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
